packet_injector: RTL and testbench
==================================

Name: packet_injector

Overview:
- Write-side packet source for a router input FIFO in the 2x2 mesh emulator.
- Accepts one packet request (destination, length), then emits a header flit, zero or more body flits, and one tail flit into the FIFO.
- Writes are throttled by the FIFO full flag.
- The downstream read side sees a header first and a tail last, so it re-arms its read enable on every tail.

Parameters:
- DATA_WIDTH, 32, flit width including the 3-bit type field.
- ADDR_WIDTH, 2, router address width (x,y bits).
- LEN_WIDTH, 4, width of the packet length field (total flits).
- SRC_ADDR, 0, this node's address, placed in the header.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  1  packet request present.
- req_ready  output  1  injector idle and able to accept a request.
- req_dst  input  ADDR_WIDTH  destination router address.
- req_len  input  LEN_WIDTH  total flits including header and tail.
- full  input  1  FIFO full flag.
- wr_en  output  1  FIFO write strobe.
- flit_out  output  DATA_WIDTH  flit written when wr_en=1.
- pkt_count  output  16  packets completed (see Optional Feature).

Behaviour:
- Flit format:
  - flit_out[DATA_WIDTH-1:DATA_WIDTH-3] = type, one-hot: 001 header, 010 body, 100 tail.
  - Header payload, LSB up: dst[ADDR_WIDTH], SRC_ADDR[ADDR_WIDTH], len[LEN_WIDTH], pkt_id[8]; remaining bits 0.
  - Body/tail payload: [7:0] flit index within packet (header = 0, so the first body flit = 1), [15:8] pkt_id; remaining bits 0.
  - DATA_WIDTH must be >= 3 + max(2*ADDR_WIDTH+LEN_WIDTH+8, 16).
- States: IDLE, HEADER, BODY, TAIL.
- IDLE:
  - req_ready=1.
  - On req_valid=1, latch dst and len and go to HEADER.
  - len is clamped: req_len<2 is treated as 2.
- wr_en = !rst && state!=IDLE && !full. This is combinational, so the write occurs in the same cycle full is sampled low.
- flit_out is driven from registered state and counters.
- A flit advances only on a cycle with wr_en=1. Otherwise state, index and flit_out hold.
- HEADER:
  - On write, set idx=1.
  - Go to BODY if len>2, else go to TAIL.
- BODY:
  - On write, idx++.
  - Go to TAIL when idx==len-2 at the write; otherwise stay in BODY.
- TAIL:
  - On write, pkt_id++ (8-bit, wraps 255->0).
  - Go to IDLE; req_ready rises the next cycle.
- Rate and latency:
  - Minimum latency from request accept to header write is 1 cycle.
  - Maximum rate is one flit per cycle.
  - A back-to-back request costs one idle cycle between packets.
- full asserted mid-packet: stall with no flit lost or duplicated; resume on the cycle full deasserts.
- Reset:
  - Values: state=IDLE, pkt_id=0, idx=0, wr_en=0, req_ready=1 after the reset edge, flit_out=0, pkt_count=0.
  - wr_en is forced 0 during any cycle rst=1.
  - Reset mid-packet abandons the packet: no tail is sent and pkt_id is not incremented.
- req_valid outside IDLE is ignored. The requester must hold req_dst and req_len stable while req_valid=1 and req_ready=1.

Optional Feature:
- Macro PKT_CNT_EN.
- Defined:
  - pkt_count increments by 1 on each tail write.
  - Saturates at 16'hFFFF.
  - Cleared by rst.
- Undefined: pkt_count is tied to 0 and no counter logic is built.

Test Plan:
- Reset, then req_dst=3, req_len=4, full=0 -> 4 consecutive writes:
  - header type 001, dst=3, src=0, len=4, id=0.
  - body idx 1, 2 (type 010).
  - tail idx 3 (type 100).
  - req_ready=1 one cycle after the tail.
- req_len=0, then req_len=2 -> each request produces exactly header+tail (2 writes), with pkt_id 0 then 1.
- req_len=5 with full=1 for 3 cycles after the second write -> wr_en=0 for those cycles, flit_out held, remaining 3 flits in order, no duplicates.
- 256 back-to-back 2-flit packets -> pkt_id wraps from 255 to 0; with PKT_CNT_EN, pkt_count=256.
- rst asserted while in BODY -> wr_en=0 that cycle; IDLE and req_ready=1 next; next header has pkt_id equal to the pre-reset value reset to 0.
- req_valid pulsed during an active packet -> ignored; no extra header appears.

Source files
------------

// File: rtl/packet_injector.sv
// Write-side packet source for a router input FIFO: emits header, body and tail flits per request.
// Optional macro PKT_CNT_EN builds a saturating completed-packet counter on pkt_count.
module packet_injector #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 2,
   parameter int unsigned LEN_WIDTH  = 4,
   parameter int unsigned SRC_ADDR   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_dst,
   input  logic [LEN_WIDTH-1:0]  req_len,
   input  logic                  full,
   output logic                  wr_en,
   output logic [DATA_WIDTH-1:0] flit_out,
   output logic [15:0]           pkt_count
);

   localparam int unsigned LenLsb = 2 * ADDR_WIDTH;
   localparam int unsigned IdLsb  = 2 * ADDR_WIDTH + LEN_WIDTH;

   typedef enum logic [1:0] {StIdle, StHeader, StBody, StTail} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] dst_q, dst_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  idx_q, idx_d;
   logic [7:0]            pkt_id_q, pkt_id_d;

   assign req_ready = (state_q == StIdle);
   assign wr_en     = !rst && (state_q != StIdle) && !full;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         dst_q    <= '0;
         len_q    <= '0;
         idx_q    <= '0;
         pkt_id_q <= '0;
      end else begin
         state_q  <= state_d;
         dst_q    <= dst_d;
         len_q    <= len_d;
         idx_q    <= idx_d;
         pkt_id_q <= pkt_id_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      dst_d    = dst_q;
      len_d    = len_q;
      idx_d    = idx_q;
      pkt_id_d = pkt_id_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               dst_d   = req_dst;
               // A packet always carries at least a header and a tail.
               len_d   = (req_len < LEN_WIDTH'(2)) ? LEN_WIDTH'(2) : req_len;
               idx_d   = '0;
               state_d = StHeader;
            end
         end
         StHeader: begin
            if (wr_en) begin
               idx_d   = LEN_WIDTH'(1);
               state_d = (len_q > LEN_WIDTH'(2)) ? StBody : StTail;
            end
         end
         StBody: begin
            if (wr_en) begin
               idx_d = idx_q + LEN_WIDTH'(1);
               if (idx_q == len_q - LEN_WIDTH'(2)) state_d = StTail;
            end
         end
         StTail: begin
            if (wr_en) begin
               pkt_id_d = pkt_id_q + 8'd1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      flit_out = '0;
      unique case (state_q)
         StHeader: begin
            flit_out[DATA_WIDTH-1 -: 3]        = 3'b001;
            flit_out[ADDR_WIDTH-1:0]           = dst_q;
            flit_out[ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(SRC_ADDR);
            flit_out[LenLsb +: LEN_WIDTH]      = len_q;
            flit_out[IdLsb +: 8]               = pkt_id_q;
         end
         StBody: begin
            flit_out[DATA_WIDTH-1 -: 3] = 3'b010;
            flit_out[7:0]               = 8'(idx_q);
            flit_out[15:8]              = pkt_id_q;
         end
         StTail: begin
            flit_out[DATA_WIDTH-1 -: 3] = 3'b100;
            flit_out[7:0]               = 8'(idx_q);
            flit_out[15:8]              = pkt_id_q;
         end
         default: flit_out = '0;
      endcase
   end

`ifdef PKT_CNT_EN
   logic [15:0] pkt_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_count_q <= '0;
      end else if (wr_en && (state_q == StTail) && (pkt_count_q != 16'hFFFF)) begin
         pkt_count_q <= pkt_count_q + 16'd1;
      end
   end

   assign pkt_count = pkt_count_q;
`else
   assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_packet_injector.sv
// Scoreboard bench for packet_injector: stimulus pushes expected flits, a negedge monitor pops them
// on every write and flags any unexpected write.
module tb_packet_injector;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_dst;
   logic [3:0]  req_len;
   logic        full;
   logic        wr_en;
   logic [31:0] flit_out;
   logic [15:0] pkt_count;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_exp;

   always #5 clk = ~clk;

   packet_injector dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_dst  (req_dst),
      .req_len  (req_len),
      .full     (full),
      .wr_en    (wr_en),
      .flit_out (flit_out),
      .pkt_count(pkt_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk_hdr(input logic [1:0] d, input logic [3:0] l,
                                          input logic [7:0] id);
      return {3'b001, 13'b0, id, l, 2'b00, d};
   endfunction

   function automatic logic [31:0] mk_flit(input logic [2:0] typ, input logic [7:0] idx,
                                           input logic [7:0] id);
      return {typ, 13'b0, id, idx};
   endfunction

   task automatic expect_pkt(input logic [1:0] d, input logic [3:0] l, input logic [7:0] id);
      logic [3:0] cl;
      cl = (l < 4'd2) ? 4'd2 : l;
      exp_q.push_back(mk_hdr(d, cl, id));
      for (int i = 1; i < int'(cl) - 1; i++) exp_q.push_back(mk_flit(3'b010, 8'(i), id));
      exp_q.push_back(mk_flit(3'b100, 8'(cl - 4'd1), id));
   endtask

   // Monitor: every write must match the head of the scoreboard.
   always @(negedge clk) begin
      if (wr_en) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got flit %h, expected no write", flit_out);
         end else begin
            mon_exp = exp_q.pop_front();
            check("flit", flit_out, mon_exp);
         end
      end
   end

   task automatic send(input logic [1:0] d, input logic [3:0] l);
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL ready_timeout: got req_ready=0, expected 1 within 200 cycles");
      end
      req_valid = 1'b1;
      req_dst   = d;
      req_len   = l;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: got %0d flits pending, expected 0", exp_q.size());
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_dst   = '0;
      req_len   = '0;
      full      = 1'b0;

      // Reset state.
      do_reset();
      @(negedge clk);
      check("reset_req_ready", 32'(req_ready), 32'd1);
      check("reset_wr_en", 32'(wr_en), 32'd0);
      check("reset_flit_out", flit_out, 32'h0);
      check("reset_pkt_count", 32'(pkt_count), 32'd0);

      // dst=3, len=4: header, body 1, body 2, tail 3.
      exp_q.push_back(32'h2000_0043);
      exp_q.push_back(32'h4000_0001);
      exp_q.push_back(32'h4000_0002);
      exp_q.push_back(32'h8000_0003);
      send(2'd3, 4'd4);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("ready_during_tail", 32'(req_ready), 32'd0);
      @(negedge clk);
      check("ready_after_tail", 32'(req_ready), 32'd1);
      check("idle_after_tail_wr_en", 32'(wr_en), 32'd0);
      drain();

      // len=0 clamps to 2, then len=2; ids 0 and 1.
      do_reset();
      exp_q.push_back(32'h2000_0023);
      exp_q.push_back(32'h8000_0001);
      exp_q.push_back(32'h2000_0123);
      exp_q.push_back(32'h8000_0101);
      send(2'd3, 4'd0);
      send(2'd3, 4'd2);
      drain();

      // len=5 (id 2) with full held for 3 cycles after the second write.
      exp_q.push_back(32'h2000_0251);
      exp_q.push_back(32'h4000_0201);
      exp_q.push_back(32'h4000_0202);
      exp_q.push_back(32'h4000_0203);
      exp_q.push_back(32'h8000_0204);
      send(2'd1, 4'd5);
      @(posedge clk);
      @(posedge clk);
      #1;
      full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_wr_en", 32'(wr_en), 32'd0);
         check("stall_flit_held", flit_out, 32'h4000_0202);
         @(posedge clk);
         #1;
      end
      full = 1'b0;
      drain();

      // 256 back-to-back 2-flit packets, then one more to show the id wrap.
      do_reset();
      for (int k = 0; k < 256; k++) begin
         expect_pkt(2'(k), 4'd2, 8'(k));
         send(2'(k), 4'd2);
      end
      drain();
`ifdef PKT_CNT_EN
      check("pkt_count_256", 32'(pkt_count), 32'd256);
`else
      check("pkt_count_tied", 32'(pkt_count), 32'd0);
`endif
      expect_pkt(2'd0, 4'd2, 8'd0);
      send(2'd0, 4'd2);
      drain();
`ifdef PKT_CNT_EN
      check("pkt_count_257", 32'(pkt_count), 32'd257);
`else
      check("pkt_count_tied2", 32'(pkt_count), 32'd0);
`endif

      // Reset while in BODY: packet abandoned, next header uses id 0.
      exp_q.push_back(mk_hdr(2'd2, 4'd6, 8'd1));
      send(2'd2, 4'd6);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("wr_en_in_reset", 32'(wr_en), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_ready", 32'(req_ready), 32'd1);
      check("post_reset_wr_en", 32'(wr_en), 32'd0);
      check("post_reset_flit", flit_out, 32'h0);
      check("post_reset_pkt_count", 32'(pkt_count), 32'd0);
      expect_pkt(2'd2, 4'd3, 8'd0);
      send(2'd2, 4'd3);
      drain();

      // req_valid pulsed mid-packet must be ignored.
      expect_pkt(2'd1, 4'd4, 8'd1);
      send(2'd1, 4'd4);
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_dst   = 2'd2;
      req_len   = 4'd2;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      drain();
      repeat (5) @(negedge clk);
      check("final_ready", 32'(req_ready), 32'd1);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
